// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and opcode constants for the multi-cycle RV32I control path
package rv32i_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP,
    S_TRAP_HOLD
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_type_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_FN  = 2'b01,
    ALU_CMP = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    C_OP,
    C_OPIMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_FENCE,
    C_SYSTEM,
    C_ILL
  } op_class_t;

endpackage

// File: rtl/rv32i_op_class.sv
// rv32i_op_class: opcode classification, immediate format and illegal flag
module rv32i_op_class
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls,
  output imm_type_t  imm_type,
  output logic       illegal
);

  // a full 7-bit match also rejects inst[1:0] != 11
  always_comb begin
    case (opcode)
      OPC_OP:     cls = C_OP;
      OPC_OPIMM:  cls = C_OPIMM;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      OPC_BRANCH: cls = C_BRANCH;
      OPC_JAL:    cls = C_JAL;
      OPC_JALR:   cls = C_JALR;
      OPC_LUI:    cls = C_LUI;
      OPC_AUIPC:  cls = C_AUIPC;
      OPC_FENCE:  cls = C_FENCE;
      OPC_SYSTEM: cls = C_SYSTEM;
      default:    cls = C_ILL;
    endcase
  end

  always_comb begin
    imm_type = cls == C_STORE ? IMM_S :
               cls == C_BRANCH ? IMM_B :
               cls inside {C_LUI, C_AUIPC} ? IMM_U :
               cls == C_JAL ? IMM_J : IMM_I;
  end

  assign illegal = cls inside {C_SYSTEM, C_ILL};

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a shared-ALU,
// single-memory-port RV32I datapath
module rv32i_mc_ctrl
  import rv32i_pkg::*;
#(
  parameter int RESET_TRAP_CLR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [2:0]  imm_type,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        instret,
  output logic        trap
);

  state_t    state, state_nx;
  op_class_t cls;
  imm_type_t imm_dec;
  logic      illegal;
  logic      ex_a, ex_b, is_ld, is_st;
  alu_op_t   ex_op;
  pc_src_t   wb_pc;
  wb_sel_t   wb_mux;
  logic      unused_inst;

  rv32i_op_class u_op_class (
    .opcode   (inst[6:0]),
    .cls      (cls),
    .imm_type (imm_dec),
    .illegal  (illegal)
  );

  assign unused_inst = ^inst[31:7];

  assign is_ld  = cls == C_LOAD;
  assign is_st  = cls == C_STORE;
  assign ex_a   = cls == C_AUIPC;
  assign ex_b   = cls inside {C_OPIMM, C_LOAD, C_STORE, C_AUIPC, C_JALR};
  assign ex_op  = cls inside {C_OP, C_OPIMM} ? ALU_FN : cls == C_BRANCH ? ALU_CMP : ALU_ADD;
  assign wb_pc  = cls == C_JAL ? PC_IMM : cls == C_JALR ? PC_ALU : PC_PLUS4;
  assign wb_mux = is_ld ? WB_MEM : cls inside {C_JAL, C_JALR} ? WB_PC4 :
                  cls == C_LUI ? WB_IMM : WB_ALU;

  // without trap clearing, the first reset out of TRAP only parks in TRAP_HOLD
  always_ff @(posedge clk) begin
    if (!rst)
      state <= (RESET_TRAP_CLR == 0 && state == S_TRAP) ? S_TRAP_HOLD : S_FETCH;
    else
      state <= state_nx;
  end

  always_comb begin
    case (state)
      S_FETCH:     state_nx = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_nx = illegal ? S_TRAP : S_EXEC;
      S_EXEC:      state_nx = cls == C_BRANCH ? S_FETCH : (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:       state_nx = !mem_ready ? S_MEM : is_ld ? S_WB : S_FETCH;
      S_WB:        state_nx = S_FETCH;
      S_TRAP:      state_nx = S_TRAP;
      S_TRAP_HOLD: state_nx = S_TRAP_HOLD;
      default:     state_nx = S_FETCH;
    endcase
  end

  // ALU operands stay applied through MEM and WB: there is no ALU output register
  always_comb begin
    imm_type     = IMM_I;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    instret      = 1'b0;
    trap         = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_DECODE: imm_type = imm_dec;
        S_EXEC: begin
          imm_type  = imm_dec;
          alu_a_sel = ex_a;
          alu_b_sel = ex_b;
          alu_op    = ex_op;
          pc_we     = cls == C_BRANCH;
          instret   = cls == C_BRANCH;
          pc_src    = (cls == C_BRANCH && br_taken) ? PC_IMM : PC_PLUS4;
        end
        S_MEM: begin
          imm_type     = imm_dec;
          alu_a_sel    = ex_a;
          alu_b_sel    = ex_b;
          alu_op       = ex_op;
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_st;
          pc_we        = is_st && mem_ready;
          instret      = is_st && mem_ready;
        end
        S_WB: begin
          imm_type  = imm_dec;
          alu_a_sel = ex_a;
          alu_b_sel = ex_b;
          alu_op    = ex_op;
          pc_we     = 1'b1;
          instret   = 1'b1;
          rf_we     = cls != C_FENCE;
          wb_sel    = wb_mux;
          pc_src    = wb_pc;
        end
        S_TRAP, S_TRAP_HOLD: trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb_rv32i_mc_ctrl: scoreboard bench, one expected output vector per clock cycle
module tb_rv32i_mc_ctrl;

  typedef struct packed {
    logic [2:0] imm_type;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       instret;
    logic       trap;
  } outs_t;

  typedef struct {
    string tag;
    outs_t v;
    outs_t m;
  } exp_t;

  localparam outs_t ALL   = 19'h7FFFF;
  localparam outs_t NOALU = 19'h7F0FF;
  localparam outs_t NOSEL = 19'h7F3FF;
  localparam outs_t ZERO  = 19'h00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [2:0]  imm_type;
  logic        ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we;
  logic        mem_req, mem_we, mem_addr_sel, instret, trap;
  logic [1:0]  pc_src, alu_op, wb_sel;
  outs_t       obs;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rv32i_mc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst         (inst),
    .mem_ready    (mem_ready),
    .br_taken     (br_taken),
    .imm_type     (imm_type),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .instret      (instret),
    .trap         (trap)
  );

  assign obs = {imm_type, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel, alu_op,
                rf_we, wb_sel, mem_req, mem_we, mem_addr_sel, instret, trap};

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs & e.m, e.v & e.m);
    end
  end

  task automatic cyc(input string tag, input logic r, input logic rdy, input outs_t v, input outs_t m);
    exp_t e;
    rst = r;
    mem_ready = rdy;
    e.tag = tag;
    e.v = v;
    e.m = m;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("rst_a", 1'b0, 1'b1, ZERO, ALL);
    cyc("rst_b", 1'b0, 1'b1, ZERO, ALL);

    inst = 32'h00500093;
    cyc("addi_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("addi_d",  1'b1, 1'b1, ZERO, NOALU);
    cyc("addi_e",  1'b1, 1'b1, outs_t'{alu_b_sel:1'b1, alu_op:2'b01, default:'0}, ALL);
    cyc("addi_wb", 1'b1, 1'b1, outs_t'{rf_we:1'b1, pc_we:1'b1, instret:1'b1, default:'0}, NOALU);

    inst = 32'h00402103;
    cyc("lw_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("lw_d",  1'b1, 1'b1, ZERO, NOALU);
    cyc("lw_e",  1'b1, 1'b1, outs_t'{alu_b_sel:1'b1, default:'0}, ALL);
    cyc("lw_m0", 1'b1, 1'b0, outs_t'{mem_req:1'b1, mem_addr_sel:1'b1, default:'0}, NOALU);
    cyc("lw_m1", 1'b1, 1'b0, outs_t'{mem_req:1'b1, mem_addr_sel:1'b1, default:'0}, NOALU);
    cyc("lw_m2", 1'b1, 1'b1, outs_t'{mem_req:1'b1, mem_addr_sel:1'b1, default:'0}, NOALU);
    cyc("lw_wb", 1'b1, 1'b1, outs_t'{rf_we:1'b1, wb_sel:2'b01, pc_we:1'b1, instret:1'b1, default:'0}, NOALU);

    inst = 32'h00102223;
    cyc("sw_fw", 1'b1, 1'b0, outs_t'{mem_req:1'b1, default:'0}, NOALU);
    cyc("sw_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("sw_d",  1'b1, 1'b1, outs_t'{imm_type:3'b001, default:'0}, NOALU);
    cyc("sw_e",  1'b1, 1'b1, outs_t'{imm_type:3'b001, alu_b_sel:1'b1, default:'0}, ALL);
    cyc("sw_m",  1'b1, 1'b1, outs_t'{imm_type:3'b001, mem_req:1'b1, mem_we:1'b1, mem_addr_sel:1'b1,
                                     pc_we:1'b1, instret:1'b1, default:'0}, NOALU);

    inst = 32'h00000463;
    br_taken = 1'b1;
    cyc("beqt_f", 1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("beqt_d", 1'b1, 1'b1, outs_t'{imm_type:3'b010, default:'0}, NOALU);
    cyc("beqt_e", 1'b1, 1'b1, outs_t'{imm_type:3'b010, alu_op:2'b10, pc_we:1'b1, pc_src:2'b01,
                                      instret:1'b1, default:'0}, NOSEL);
    br_taken = 1'b0;
    cyc("beqn_f", 1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("beqn_d", 1'b1, 1'b1, outs_t'{imm_type:3'b010, default:'0}, NOALU);
    cyc("beqn_e", 1'b1, 1'b1, outs_t'{imm_type:3'b010, alu_op:2'b10, pc_we:1'b1, instret:1'b1,
                                      default:'0}, NOSEL);

    inst = 32'h010000EF;
    cyc("jal_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("jal_d",  1'b1, 1'b1, outs_t'{imm_type:3'b100, default:'0}, NOALU);
    cyc("jal_e",  1'b1, 1'b1, outs_t'{imm_type:3'b100, default:'0}, NOALU);
    cyc("jal_wb", 1'b1, 1'b1, outs_t'{imm_type:3'b100, rf_we:1'b1, wb_sel:2'b10, pc_we:1'b1,
                                      pc_src:2'b01, instret:1'b1, default:'0}, NOALU);

    inst = 32'h000100E7;
    cyc("jalr_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("jalr_d",  1'b1, 1'b1, ZERO, NOALU);
    cyc("jalr_e",  1'b1, 1'b1, outs_t'{alu_b_sel:1'b1, default:'0}, ALL);
    cyc("jalr_wb", 1'b1, 1'b1, outs_t'{alu_b_sel:1'b1, rf_we:1'b1, wb_sel:2'b10, pc_we:1'b1,
                                       pc_src:2'b10, instret:1'b1, default:'0}, ALL);

    inst = 32'h00402103;
    cyc("lwr_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("lwr_d",  1'b1, 1'b1, ZERO, NOALU);
    cyc("lwr_e",  1'b1, 1'b1, outs_t'{alu_b_sel:1'b1, default:'0}, ALL);
    cyc("lwr_m",  1'b1, 1'b0, outs_t'{mem_req:1'b1, mem_addr_sel:1'b1, default:'0}, NOALU);
    cyc("lwr_rst", 1'b0, 1'b1, ZERO, ALL);
    inst = 32'h0000000F;
    cyc("rst_fw", 1'b1, 1'b0, outs_t'{mem_req:1'b1, default:'0}, NOALU);
    cyc("fen_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("fen_d",  1'b1, 1'b1, ZERO, NOALU);
    cyc("fen_e",  1'b1, 1'b1, ZERO, NOALU);
    cyc("fen_wb", 1'b1, 1'b1, outs_t'{pc_we:1'b1, instret:1'b1, default:'0}, NOALU);

    inst = 32'h00000000;
    cyc("ill_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("ill_d",  1'b1, 1'b1, ZERO, ALL);
    cyc("ill_t0", 1'b1, 1'b1, outs_t'{trap:1'b1, default:'0}, ALL);
    cyc("ill_t1", 1'b1, 1'b1, outs_t'{trap:1'b1, default:'0}, ALL);
    cyc("ill_t2", 1'b1, 1'b0, outs_t'{trap:1'b1, default:'0}, ALL);
    cyc("ill_rst", 1'b0, 1'b1, ZERO, ALL);

    inst = 32'h00000073;
    cyc("sys_f",  1'b1, 1'b1, outs_t'{mem_req:1'b1, ir_we:1'b1, default:'0}, NOALU);
    cyc("sys_d",  1'b1, 1'b1, ZERO, ALL);
    cyc("sys_t",  1'b1, 1'b1, outs_t'{trap:1'b1, default:'0}, ALL);
    cyc("sys_rst", 1'b0, 1'b1, ZERO, ALL);
    cyc("end_f",  1'b1, 1'b0, outs_t'{mem_req:1'b1, default:'0}, NOALU);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I datapath: instruction fetch, decode, execute, memory access and writeback. It drives imm_type to the immediate sign extender and generates all enables and mux selects for the PC, IR, register file, ALU and memory port. It replaces per-instruction combinational control, so a single memory port and a single ALU are shared across the phases of each instruction.

Parameters:
RESET_TRAP_CLR, 1, 1 = rst clears the sticky trap state; 0 = trap persists until a second rst (debug builds only).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-low reset
inst  in  32  IR contents; valid from DECODE onward
mem_ready  in  1  memory completes the current request this cycle
br_taken  in  1  branch comparator result; sampled in EXEC only
imm_type  out  3  000 I, 001 S, 010 B, 011 U, 100 J
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_src  out  2  00 pc+4, 01 pc+imm, 10 alu result with bit0 cleared (JALR)
alu_a_sel  out  1  0 rs1, 1 pc
alu_b_sel  out  1  0 rs2, 1 imm
alu_op  out  2  00 add, 01 funct3/funct7 decoded, 10 compare (branch)
rf_we  out  1  register file write
wb_sel  out  2  00 alu, 01 mem rdata, 10 pc+4, 11 imm
mem_req  out  1  memory request
mem_we  out  1  store when mem_req is high
mem_addr_sel  out  1  0 pc, 1 alu result
instret  out  1  one-cycle pulse per retired instruction
trap  out  1  sticky: illegal or SYSTEM instruction seen

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- State register is the only sequential element.
- Outputs are combinational from state and inst. Exceptions: ir_we and the MEM exit depend on mem_ready; pc_src in EXEC depends on br_taken.
- Reset: rst low at a clock edge forces FETCH. While rst is low, every output is 0, including imm_type=000.
  - Reset in the middle of MEM drops mem_req on the next cycle.
  - A late mem_ready is ignored.
- Handshake: mem_req stays high with stable mem_we and mem_addr_sel until mem_ready is sampled high. mem_ready while mem_req is low is ignored. Zero-wait-state memory is legal.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0.
  - When mem_ready=1: ir_we=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Classifies the opcode.
  - inst[1:0] != 11, an unknown opcode, or SYSTEM (1110011) goes to TRAP. Everything else goes to EXEC.
- imm_type from the opcode, driven in DECODE through WB:
  - LOAD, OP-IMM, JALR: I.
  - STORE: S.
  - BRANCH: B.
  - LUI, AUIPC: U.
  - JAL: J.
  - Anything else: 000.
- EXEC:
  - OP: a=rs1, b=rs2, alu_op=01. Next: WB.
  - OP-IMM: a=rs1, b=imm, alu_op=01. Next: WB.
  - LOAD/STORE: a=rs1, b=imm, alu_op=00. Next: MEM.
  - AUIPC: a=pc, b=imm, alu_op=00. Next: WB.
  - LUI, JAL, FENCE: no ALU use. Next: WB.
  - JALR: a=rs1, b=imm, alu_op=00. Next: WB.
  - BRANCH: alu_op=10, pc_we=1, pc_src = br_taken ? 01 : 00, instret=1. Next: FETCH.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=(STORE).
  - On mem_ready: LOAD goes to WB. STORE sets pc_we=1, pc_src=00, instret=1 and goes to FETCH.
- WB:
  - pc_we=1 and instret=1, then go to FETCH.
  - rf_we=1 except for FENCE. The x0 write is discarded by the register file.
  - wb_sel per class: OP/OP-IMM/AUIPC 00 (JALR keeps the ALU result for pc_src). LOAD 01. JAL/JALR 10. LUI 11.
  - pc_src per class: JAL 01, JALR 10, all others 00.
  - JALR holds the EXEC ALU operands so the ALU result stays stable.
- Cycle counts: branch 3; ALU/LUI/AUIPC/JAL/JALR/FENCE/store 4; load 5; each memory wait state adds 1.
- TRAP:
  - trap=1 and all other outputs 0.
  - Stays in TRAP until rst. rst with RESET_TRAP_CLR=1 returns to FETCH.

Decomposition:
- rv32i_pkg holds:
  - state_t enum.
  - Opcode localparams.
  - imm_type_t enum, with the encodings above shared with the sign extender.
  - pc_src_t, wb_sel_t, alu_op_t.
- One natural sub-module: rv32i_op_class, a combinational decode of inst into an opcode class, the imm_type and an illegal flag. It is reused by the sign-extender path.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready always 1 -> FETCH, DECODE, EXEC, WB; imm_type=000; WB has rf_we=1, wb_sel=00, pc_we=1, pc_src=00, instret=1; the next FETCH begins in cycle 5.
- lw x2,4(x0) (0x00402103), 2 wait states in MEM -> mem_req=1, mem_addr_sel=1, mem_we=0 held for 3 cycles; then WB with wb_sel=01; 7 cycles total.
- sw x1,4(x0) (0x00102223) -> imm_type=001; MEM has mem_we=1; retires from MEM with pc_we=1; rf_we is never 1.
- beq x0,x0,8 (0x00000463) with br_taken=1 -> imm_type=010; EXEC has alu_op=10, pc_we=1, pc_src=01; 3 cycles; rerun with br_taken=0 -> pc_src=00.
- jal x1,16 (0x010000EF) -> imm_type=100; WB has rf_we=1, wb_sel=10, pc_src=01.
- inst=0x00000000 -> DECODE goes to TRAP, trap=1 sticky, no pc_we or rf_we. Separately, rst=0 during a MEM wait -> next cycle all outputs 0; after rst=1 the block is in FETCH with mem_addr_sel=0.
